// File: rtl/clk_div_checker.sv
// rtl/clk_div_checker.sv - period/high-time monitor for integer clock dividers
//
// Purpose:
//   Samples a flop-generated divided clock in the source clock domain and
//   measures its period and sampled high time in source-clock cycles. Lock is
//   reported after LOCK_CNT consecutive in-tolerance periods. A sticky error
//   flags a bad period while locked, or a divided clock that stops toggling.
//
// Ports:
//   clk_i         in   1      source clock, all logic on posedge
//   rst_i         in   1      synchronous active-high reset
//   div_clk_i     in   1      divided clock under test
//   en_i          in   1      measurement enable; low idles and clears
//   period_o      out  CNT_W  last measured period (clk_i cycles)
//   high_o        out  CNT_W  last measured high time (posedge samples at 1)
//   meas_valid_o  out  1      one-cycle pulse when period_o/high_o update
//   lock_o        out  1      LOCK_CNT consecutive in-tolerance periods seen
//   err_o         out  1      sticky: mismatch while locked, or timeout
module clk_div_checker #(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 6,
  parameter int EXP_HIGH   = 3,
  parameter int TOL        = 0,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             div_clk_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             meas_valid_o,
  output logic             lock_o,
  output logic             err_o
);

  localparam int MC_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0] EXP_P     = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] EXP_H     = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [MC_W-1:0]  LOCK_M    = MC_W'(LOCK_CNT);
  localparam logic [MC_W-1:0]  MC_ONE    = MC_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [MC_W-1:0]  mcnt_q, mcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             lock_q, lock_d;
  logic             err_q, err_d;

  logic             rise;
  logic [CNT_W-1:0] p_diff;
  logic [CNT_W-1:0] h_diff;
  logic             match;

  assign rise = div_clk_i & ~div_q;

  // Larger-minus-smaller keeps the deviation unsigned and wrap-free.
  assign p_diff = (cnt_q >= EXP_P) ? (cnt_q - EXP_P) : (EXP_P - cnt_q);
  assign h_diff = (hcnt_q >= EXP_H) ? (hcnt_q - EXP_H) : (EXP_H - hcnt_q);
  assign match  = (p_diff <= TOL_C) && (h_diff <= TOL_C);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      div_q    <= 1'b0;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      mcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      lock_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      mcnt_q   <= mcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      lock_q   <= lock_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_clk_i;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    mcnt_d   = mcnt_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    lock_d   = lock_q;
    err_d    = err_q;

    if (!en_i) begin
      // Disable has priority over everything, including a coincident rise.
      state_d  = IDLE;
      cnt_d    = '0;
      hcnt_d   = '0;
      mcnt_d   = '0;
      period_d = '0;
      high_d   = '0;
      lock_d   = 1'b0;
      err_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SYNC;
        end

        SYNC: begin
          if (rise) begin
            cnt_d   = CNT_ONE;
            hcnt_d  = CNT_ONE;
            state_d = MEASURE;
          end
        end

        MEASURE: begin
          if (rise) begin
            period_d = cnt_q;
            high_d   = hcnt_q;
            valid_d  = 1'b1;
            // The rise-edge sample is the first high sample of the new period.
            cnt_d    = CNT_ONE;
            hcnt_d   = CNT_ONE;
            if (match) begin
              if (mcnt_q != LOCK_M) begin
                mcnt_d = mcnt_q + MC_ONE;
              end
              if (mcnt_q >= LOCK_M - MC_ONE) begin
                lock_d = 1'b1;
              end
            end else begin
              mcnt_d = '0;
              lock_d = 1'b0;
              if (lock_q) begin
                err_d = 1'b1;
              end
            end
          end else if (cnt_q >= TIMEOUT_C) begin
            // Divided clock stopped toggling: drop lock and resynchronise.
            err_d   = 1'b1;
            lock_d  = 1'b0;
            mcnt_d  = '0;
            state_d = SYNC;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            if (div_clk_i && (hcnt_q != CNT_MAX)) begin
              hcnt_d = hcnt_q + CNT_ONE;
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign period_o     = period_q;
  assign high_o       = high_q;
  assign meas_valid_o = valid_q;
  assign lock_o       = lock_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_clk_div_checker.sv
// tb/tb_clk_div_checker.sv - self-checking bench for clk_div_checker
module tb_clk_div_checker;

  localparam int EXP_P  = 6;
  localparam int EXP_H  = 3;
  localparam int LOCK_N = 4;
  localparam int TMO    = 24;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       div;
  logic [7:0] per0, hi0, per1, hi1;
  logic       v0, l0, e0, v1, l1, e1;

  int n_assert = 0;
  int n_fail   = 0;

  clk_div_checker #(
    .CNT_W(8), .EXP_PERIOD(EXP_P), .EXP_HIGH(EXP_H), .TOL(0),
    .LOCK_CNT(LOCK_N), .TIMEOUT(TMO)
  ) dut0 (
    .clk_i(clk), .rst_i(rst), .div_clk_i(div), .en_i(en),
    .period_o(per0), .high_o(hi0), .meas_valid_o(v0),
    .lock_o(l0), .err_o(e0)
  );

  clk_div_checker #(
    .CNT_W(8), .EXP_PERIOD(EXP_P), .EXP_HIGH(EXP_H), .TOL(1),
    .LOCK_CNT(LOCK_N), .TIMEOUT(TMO)
  ) dut1 (
    .clk_i(clk), .rst_i(rst), .div_clk_i(div), .en_i(en),
    .period_o(per1), .high_o(hi1), .meas_valid_o(v1),
    .lock_o(l1), .err_o(e1)
  );

  always #5 clk = ~clk;

  // Reference model: time-stamp based. A measurement is the distance in
  // cycles between two accepted rising edges plus the count of high samples
  // taken from the first of them up to (not including) the second.
  int tol_m [2] = '{0, 1};
  int phase [2];          // 0 = idle, 1 = waiting for first rise, 2 = measuring
  int ref_t [2];
  int highs [2];
  int run   [2];
  int m_per [2];
  int m_hi  [2];
  bit m_val [2];
  bit m_lock[2];
  bit m_err [2];
  bit prev_div = 1'b0;
  int t = 0;

  function automatic int iabs(int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_edge(input bit r, input bit e, input bit d);
    bit rise;
    int age;
    bit good;
    rise     = d && !prev_div;
    prev_div = r ? 1'b0 : d;
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 1'b0;
      if (r || !e) begin
        phase[i] = 0; run[i] = 0; m_per[i] = 0; m_hi[i] = 0;
        m_lock[i] = 1'b0; m_err[i] = 1'b0;
      end else if (phase[i] == 0) begin
        phase[i] = 1;
      end else if (phase[i] == 1) begin
        if (rise) begin
          phase[i] = 2; ref_t[i] = t; highs[i] = 1;
        end
      end else begin
        age = t - ref_t[i];
        if (rise) begin
          m_per[i] = age;
          m_hi[i]  = highs[i];
          m_val[i] = 1'b1;
          good = (iabs(age - EXP_P) <= tol_m[i]) && (iabs(highs[i] - EXP_H) <= tol_m[i]);
          if (good) begin
            run[i]    = (run[i] < LOCK_N) ? run[i] + 1 : LOCK_N;
            m_lock[i] = (run[i] >= LOCK_N);
          end else begin
            if (m_lock[i]) m_err[i] = 1'b1;
            run[i]    = 0;
            m_lock[i] = 1'b0;
          end
          ref_t[i] = t;
          highs[i] = 1;
        end else if (age >= TMO) begin
          m_err[i]  = 1'b1;
          m_lock[i] = 1'b0;
          run[i]    = 0;
          phase[i]  = 1;
        end else begin
          highs[i] = highs[i] + int'(d);
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    n_assert++;
    assert (obs === 32'(expv)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("dut0.period", 32'(per0), m_per[0]);
    chk("dut0.high",   32'(hi0),  m_hi[0]);
    chk("dut0.valid",  32'(v0),   int'(m_val[0]));
    chk("dut0.lock",   32'(l0),   int'(m_lock[0]));
    chk("dut0.err",    32'(e0),   int'(m_err[0]));
    chk("dut1.period", 32'(per1), m_per[1]);
    chk("dut1.high",   32'(hi1),  m_hi[1]);
    chk("dut1.valid",  32'(v1),   int'(m_val[1]));
    chk("dut1.lock",   32'(l1),   int'(m_lock[1]));
    chk("dut1.err",    32'(e1),   int'(m_err[1]));
  endtask

  // One source-clock cycle: inputs are already stable, sample 1 after edge.
  task automatic cyc(input bit d);
    div = d;
    @(posedge clk);
    #1;
    t++;
    model_edge(rst, en, d);
    check_all();
  endtask

  task automatic wave(input int p, input int h, input int n);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < p; c++) begin
        cyc(c < h);
      end
    end
  endtask

  initial begin
    int r;
    int p;
    int h;
    int hold;
    rst = 1'b1;
    en  = 1'b0;
    div = 1'b0;

    // Reset state.
    cyc(0); cyc(0); cyc(0);
    chk("reset.period", 32'(per0), 0);
    chk("reset.lock",   32'(l0),   0);
    chk("reset.err",    32'(e0),   0);
    rst = 1'b0;
    en  = 1'b1;

    // Clean divide-by-6, 3 high / 3 low.
    wave(6, 3, 8);
    chk("div6.period", 32'(per0), 6);
    chk("div6.high",   32'(hi0),  3);
    chk("div6.lock",   32'(l0),   1);
    chk("div6.err",    32'(e0),   0);

    // One stretched period while locked, then four good ones.
    wave(7, 4, 1);
    wave(6, 3, 5);
    chk("stretch.err",  32'(e0), 1);
    chk("stretch.lock", 32'(l0), 1);

    // One-cycle disable clears sticky error, then relock.
    en = 1'b0;
    cyc(0);
    chk("dis.err",    32'(e0),   0);
    chk("dis.lock",   32'(l0),   0);
    chk("dis.period", 32'(per0), 0);
    en = 1'b1;
    wave(6, 3, 6);
    chk("relock.lock", 32'(l0), 1);

    // Stuck high: timeout, then relock with the error still sticky.
    for (int k = 0; k < 30; k++) cyc(1);
    chk("stuck.err",  32'(e0), 1);
    chk("stuck.lock", 32'(l0), 0);
    wave(6, 3, 6);
    chk("stuck.relock", 32'(l0), 1);
    chk("stuck.sticky", 32'(e0), 1);

    // Tolerance of 1 with periods 5/6/7.
    en = 1'b0;
    cyc(0);
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wave(5, 2, 1);
      wave(6, 3, 1);
      wave(7, 4, 1);
    end
    cyc(1);
    chk("tol1.lock",     32'(l1), 1);
    chk("tol1.err",      32'(e1), 0);
    chk("tol0.err",      32'(e0), 0);

    // Reset mid-period while locked.
    wave(6, 3, 6);
    chk("prerst.lock", 32'(l0), 1);
    cyc(1); cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("midrst.lock",   32'(l0),   0);
    chk("midrst.period", 32'(per0), 0);
    chk("midrst.high",   32'(hi0),  0);
    cyc(0); cyc(0); cyc(0);
    wave(6, 3, 3);

    // Randomized waveforms, disables and stalls.
    for (int k = 0; k < 80; k++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        en = 1'b0;
        cyc(bit'($urandom_range(0, 1)));
        en = 1'b1;
      end else if (r == 1) begin
        hold = int'($urandom_range(20, 30));
        h    = int'($urandom_range(0, 1));
        for (int c = 0; c < hold; c++) cyc(bit'(h));
      end else if (r < 12) begin
        wave(6, 3, 1);
      end else begin
        p = int'($urandom_range(2, 9));
        h = int'($urandom_range(1, p - 1));
        wave(p, h, 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
